// File: rtl/timer_pkg.sv
// Shared types and helpers for the MM:SS countdown timer.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Units digits (even index) count mod-10, tens digits (odd index) mod-6.
  function automatic int unsigned digit_mod(input int unsigned i);
    return (i % 32'd2 == 32'd0) ? 32'd10 : 32'd6;
  endfunction

  // True when a load value fits the modulus of digit position i.
  function automatic logic digit_valid(input logic [DIGIT_W-1:0] val, input int unsigned i);
    return (32'(val) < digit_mod(i));
  endfunction

endpackage

// File: rtl/mod_n_countdown_timer_if.sv
// Control/data bundle between a timer controller and the countdown timer.
interface mod_n_countdown_timer_if
  import timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic                          tick;
  logic                          enable;
  logic                          loadn;
  logic [DIGIT_W*NUM_DIGITS-1:0] data;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits;
  logic                          tc;
  logic                          zero;
  logic                          running;
  logic                          load_err;

  modport master (
    output tick, enable, loadn, data,
    input  digits, tc, zero, running, load_err
  );

  modport slave (
    input  tick, enable, loadn, data,
    output digits, tc, zero, running, load_err
  );

endinterface

// File: rtl/mod_n_digit.sv
// One BCD digit with load, decrement-with-wrap and borrow chaining.
module mod_n_digit
  import timer_pkg::*;
#(
  parameter int unsigned MODULUS = 10
) (
  input  logic               clock,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] value,
  output logic               is_zero,
  output logic               borrow_out
);

  // Digit register: load wins, otherwise step down when every lower digit is zero.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && borrow_in) begin
      value <= (value == '0) ? DIGIT_W'(MODULUS - 1) : value - DIGIT_W'(1);
    end
  end

  assign is_zero    = (value == '0);
  assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/mod_n_countdown_timer.sv
// Multi-digit MM:SS countdown timer: validated load, hold, terminal-count pulse, optional auto-reload.
module mod_n_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter bit          RELOAD_MODE = 1'b0
) (
  input  logic                   clock,
  input  logic                   clr,
  mod_n_countdown_timer_if.slave bus
);

  localparam int unsigned W = DIGIT_W * NUM_DIGITS;

  state_t          state;
  logic [W-1:0]    shadow;
  logic [W-1:0]    digits_w;
  logic [W-1:0]    dig_load_val;
  logic [NUM_DIGITS:0]   borrow;
  logic [NUM_DIGITS-1:0] dz;
  logic            tc_q;
  logic            load_err_q;
  logic            data_ok;
  logic            load_req;
  logic            load_acc;
  logic            qual;
  logic            step;
  logic            reload;
  logic            dig_load;
  logic            all_zero;
  logic            at_one;

  // Every incoming digit must be below its own modulus for a load to be accepted.
  always_comb begin
    data_ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!digit_valid(bus.data[i*DIGIT_W +: DIGIT_W], i)) data_ok = 1'b0;
    end
  end

  assign load_req = !bus.loadn;
  assign load_acc = load_req && data_ok;

  // A qualifying tick; a load in the same cycle swallows it.
  assign qual     = (state == RUN) && bus.enable && bus.tick && !load_req;
  assign step     = qual && !all_zero;
  assign reload   = qual && all_zero && RELOAD_MODE && (shadow != '0);
  assign dig_load = load_acc || reload;
  assign dig_load_val = load_acc ? bus.data : shadow;

  // Top of the borrow chain is set only when every digit is zero.
  assign all_zero = borrow[NUM_DIGITS];
  // Count is exactly one: the next step lands on zero.
  assign at_one   = (digits_w[DIGIT_W-1:0] == DIGIT_W'(1)) && (&(dz | NUM_DIGITS'(1)));

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    mod_n_digit #(
      .MODULUS (digit_mod(g))
    ) u_digit (
      .clock      (clock),
      .clr        (clr),
      .load       (dig_load),
      .load_val   (dig_load_val[g*DIGIT_W +: DIGIT_W]),
      .dec        (step),
      .borrow_in  (borrow[g]),
      .value      (digits_w[g*DIGIT_W +: DIGIT_W]),
      .is_zero    (dz[g]),
      .borrow_out (borrow[g+1])
    );
  end

  // Control FSM, shadow register and registered pulses.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      shadow     <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
      if (load_req) begin
        if (data_ok) begin
          shadow <= bus.data;
          state  <= HOLD;
        end else begin
          load_err_q <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: ;
          HOLD: begin
            if (bus.enable && !all_zero) state <= RUN;
          end
          RUN: begin
            if (!bus.enable) begin
              state <= HOLD;
            end else if (bus.tick) begin
              if (!all_zero) begin
                if (at_one) begin
                  tc_q <= 1'b1;
                  if (!RELOAD_MODE) state <= DONE;
                end
              end else if (!RELOAD_MODE || (shadow == '0)) begin
                state <= DONE;
              end
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.digits   = digits_w;
  assign bus.zero     = all_zero;
  assign bus.running  = (state == RUN);
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

endmodule

// File: doc/mod_n_countdown_timer.md
Name: mod_n_countdown_timer

Overview:
Parametrised multi-digit countdown timer for the MM:SS display path. It chains NUM_DIGITS BCD digits with alternating moduli (mod-10 units, mod-6 tens) and decrements once per tick strobe. It adds a validated load, pause/hold, a registered terminal-count pulse and an optional auto-reload mode. Output digits feed the display decoders directly, and tc feeds the alarm/buzzer control.

Parameters:
NUM_DIGITS, 4, number of cascaded digits (even digit index = mod-10, odd index = mod-6; 4 gives MM:SS up to 59:59)
RELOAD_MODE, 0, 0 = stop at zero; 1 = reload last loaded value on the tick after reaching zero

Ports:
clock  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
tick  input  1  one-cycle count strobe (e.g. 1 Hz enable); ignored unless counting
enable  input  1  level; 1 = count allowed, 0 = hold
loadn  input  1  active-low synchronous load of data
data  input  4*NUM_DIGITS  load value, digit 0 in bits [3:0]
digits  output  4*NUM_DIGITS  current count, same packing as data
tc  output  1  registered one-cycle pulse when count reaches zero via a tick
zero  output  1  level; 1 when all digits are 0
running  output  1  1 while in state RUN
load_err  output  1  one-cycle pulse: load rejected, some data digit >= its modulus

Behaviour:
- Reset (async, clr=1): digits=0, shadow=0, state=IDLE, tc=0, zero=1, running=0, load_err=0.
- States: IDLE, HOLD, RUN, DONE. running = (state==RUN).
- Priority each edge: clr > load > tick/enable.
- Load (loadn=0), any state:
  - If every data digit < its modulus: digits<=data, shadow<=data, state<=HOLD.
  - Otherwise: load_err=1 for one cycle; digits, shadow and state are unchanged.
  - A tick in the same cycle as a load is discarded.
- IDLE: waits for a load; tick and enable are ignored.
- HOLD: enable=1 and value!=0 -> RUN on the next edge. With value==0 it stays in HOLD and tc is not generated.
- RUN:
  - enable=0 -> HOLD; digits frozen.
  - tick=1 and enable=1, value!=0: decrement with borrow chain.
    - digit i decrements iff all digits below i are 0 (digit 0 always decrements).
    - A digit at 0 that decrements wraps to MOD-1 (9 or 5).
    - Example: 01:00 -> 00:59.
  - The tick that makes value==0 sets tc=1 on the same edge; tc lasts exactly one cycle.
    - RELOAD_MODE=0: state<=DONE.
    - RELOAD_MODE=1: stay in RUN. The next qualifying tick loads digits<=shadow (no decrement), so the period is shadow+1 ticks. If shadow==0, go to DONE instead.
- DONE: digits hold 0, ticks ignored, tc=0; exits only by load (or clr).
- zero is combinational from digits (all-zero compare). tc is registered.
- Ticks spaced 1 cycle apart are legal; every qualifying tick produces exactly one step.
- clr mid-count: all outputs return to reset values immediately, including clearing a pending tc.
- Arithmetic is per-digit 4-bit, with no binary-to-BCD conversion. Digit values stay < modulus by construction; load validation guarantees this.

Decomposition:
- Package timer_pkg holds:
  - DIGIT_W=4.
  - The state enum {IDLE, HOLD, RUN, DONE}.
  - Function digit_mod(i), returning 10 for even i and 6 for odd i.
  - Function digit_valid(val, i).
- Sub-module mod_n_digit, parameter MODULUS. It is instantiated NUM_DIGITS times in a generate loop.
  - Inputs: clock, clr, load, load_val, dec, borrow_in.
  - Outputs: value, is_zero, borrow_out = borrow_in & is_zero.
  - It decrements/wraps when dec & borrow_in.
- The top level owns the FSM, shadow register, load validation, tc and load_err.

Test Plan:
- clr=1 then release, no load; pulse tick 5x with enable=1 -> digits=0000, zero=1, state IDLE, tc never asserted.
- Load data=0x0102 (01:02), enable=1, 62 ticks -> sequence 01:01, 01:00, 00:59 ... 00:01, 00:00. tc high exactly on the 62nd tick edge for 1 cycle; state DONE; further ticks leave 00:00.
- Load 0x0010, run 4 ticks (00:06), drop enable for 10 ticks, raise enable, 6 more ticks -> holds at 00:06 while disabled, then reaches 00:00 with a single tc.
- Load data=0x0070 (tens-of-seconds digit 7) -> load_err pulse 1 cycle, digits unchanged, state unchanged. Then load 0x0059 -> accepted, load_err=0.
- RELOAD_MODE=1, load 0x0003, enable=1, 12 ticks -> 02,01,00(tc),03,02,01,00(tc),03,02,01,00(tc),03: three tc pulses, period 4 ticks.
- Load 0x0005 while running mid-count in the same cycle as a tick -> digits=0005, tick discarded, state HOLD then RUN. Assert clr during RUN at 00:03 -> digits=0000, running=0 without waiting for a clock edge.
